// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//   Packs a CPU instruction field set into a 32-bit word and buffers it in a
//   2-entry FIFO. Field sets with an out-of-range constant or an unknown
//   format are accepted but dropped. A dropped set raises a one-cycle err
//   pulse and is counted in err_count.
//
// Ports
//   clk          system clock
//   nreset       synchronous active-low reset (priority over everything)
//   in_valid     field set present               in_ready   encoder can accept
//   fmt          0 RRR, 1 ALUC, 2 C16S, 3 C16U, 4 C27 (5-7 invalid)
//   instrOP      instruction opcode field
//   aluOP        ALU opcode field
//   areg         A register field
//   breg         B register field
//   dreg         D register field
//   constIn      constant, signed or unsigned depending on fmt
//   oe           offset-enable flag (C27 only)
//   flush        synchronously empties the output FIFO
//   out_valid    encoded word available
//   out_ready    consumer accepts the head word
//   out_instr    head word (32'h0 while the FIFO is empty)
//   err          one-cycle pulse after a rejected field set
//   word_count   words pushed, wrapping
//   err_count    rejected sets, saturating
// -----------------------------------------------------------------------------
module instr_encoder (
  input  logic        clk,
  input  logic        nreset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  fmt,
  input  logic [3:0]  instrOP,
  input  logic [3:0]  aluOP,
  input  logic [3:0]  areg,
  input  logic [3:0]  breg,
  input  logic [3:0]  dreg,
  input  logic [31:0] constIn,
  input  logic        oe,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        err,
  output logic [15:0] word_count,
  output logic [15:0] err_count
);

  typedef enum logic [2:0] {
    FMT_RRR  = 3'd0,
    FMT_ALUC = 3'd1,
    FMT_C16S = 3'd2,
    FMT_C16U = 3'd3,
    FMT_C27  = 3'd4
  } fmt_e;

  logic [31:0] mem_q [2];
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  count_q, count_d;
  logic        err_q;
  logic [15:0] word_count_q, err_count_q;

  logic [31:0] enc_word;
  logic        enc_ok;
  logic        accept, push, pop, reject;

  // A constant fits in 16-bit two's complement when bits 31..15 are all
  // copies of the sign bit.
  logic signed_ok, unsigned_ok, c27_ok;
  assign signed_ok   = (constIn[31:15] == 17'h00000) || (constIn[31:15] == 17'h1FFFF);
  assign unsigned_ok = (constIn[31:16] == 16'h0000);
  assign c27_ok      = (constIn[31:27] == 5'h00);

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave it unassigned and infer a latch.
  always_comb begin
    enc_word = 32'h0;
    enc_ok   = 1'b0;
    case (fmt_e'(fmt))
      FMT_RRR: begin
        enc_word = {instrOP, aluOP, 12'h000, areg, breg, dreg};
        enc_ok   = 1'b1;
      end
      FMT_ALUC: begin
        enc_word = {instrOP, aluOP, constIn[15:0], breg, dreg};
        enc_ok   = signed_ok;
      end
      FMT_C16S: begin
        enc_word = {instrOP, constIn[15:0], areg, breg, dreg};
        enc_ok   = signed_ok;
      end
      FMT_C16U: begin
        enc_word = {instrOP, constIn[15:0], areg, breg, dreg};
        enc_ok   = unsigned_ok;
      end
      FMT_C27: begin
        enc_word = {instrOP, constIn[26:0], oe};
        enc_ok   = c27_ok;
      end
      default: begin
        enc_word = 32'h0;
        enc_ok   = 1'b0;
      end
    endcase
  end

  // in_ready depends only on registered count, so out_ready has no
  // combinational path to it. A full FIFO takes no push even if it pops.
  assign in_ready = (count_q != 2'd2);
  assign accept   = in_valid && in_ready;
  assign push     = accept && enc_ok && !flush;
  assign reject   = accept && !enc_ok;
  assign pop      = out_valid && out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
      err_q        <= 1'b0;
      word_count_q <= 16'h0000;
      err_count_q  <= 16'h0000;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= reject;
      if (push)
        word_count_q <= word_count_q + 16'd1;
      if (reject && (err_count_q != 16'hFFFF))
        err_count_q <= err_count_q + 16'd1;
    end
  end

  // NOTE: the storage array is not reset. Empty entries are never observable
  // because out_instr is forced to zero while count is zero.
  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q] <= enc_word;
  end

  assign out_valid  = (count_q != 2'd0);
  assign out_instr  = out_valid ? mem_q[rd_ptr_q] : 32'h0;
  assign err        = err_q;
  assign word_count = word_count_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder
//   Directed bench for instr_encoder. The first part is a table of field sets
//   with hand-computed words, applied one per accept. Hand-written sequences
//   follow for the err pulse, backpressure, flush and mid-stream reset.
// -----------------------------------------------------------------------------
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        nreset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  fmt;
  logic [3:0]  instrOP, aluOP, areg, breg, dreg;
  logic [31:0] constIn;
  logic        oe;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        err;
  logic [15:0] word_count, err_count;

  instr_encoder dut (
    .clk        (clk),
    .nreset     (nreset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .fmt        (fmt),
    .instrOP    (instrOP),
    .aluOP      (aluOP),
    .areg       (areg),
    .breg       (breg),
    .dreg       (dreg),
    .constIn    (constIn),
    .oe         (oe),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .err        (err),
    .word_count (word_count),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  fmt;
    logic [3:0]  iop;
    logic [3:0]  aop;
    logic [3:0]  a;
    logic [3:0]  b;
    logic [3:0]  d;
    logic [31:0] c;
    logic        oe;
    logic        bad;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [14];
  int   checks = 0;
  int   errors = 0;
  logic [15:0] exp_wc = 16'h0;
  logic [15:0] exp_ec = 16'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    fmt     = v.fmt;
    instrOP = v.iop;
    aluOP   = v.aop;
    areg    = v.a;
    breg    = v.b;
    dreg    = v.d;
    constIn = v.c;
    oe      = v.oe;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_counts(input string tag);
    check({tag, " word_count"}, {16'h0, word_count}, {16'h0, exp_wc});
    check({tag, " err_count"},  {16'h0, err_count},  {16'h0, exp_ec});
  endtask

  vec_t va, vb, vc;

  initial begin
    //            fmt   iop   aop   a     b     d     const          oe    bad   word
    vecs[0]  = '{3'd0, 4'h0, 4'h5, 4'h1, 4'h2, 4'h3, 32'h0000_0000, 1'b0, 1'b0, 32'h05000123};
    vecs[1]  = '{3'd1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h7, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h10FFFF07};
    vecs[2]  = '{3'd1, 4'h2, 4'h3, 4'h0, 4'h4, 4'h5, 32'h0000_7FFF, 1'b0, 1'b0, 32'h237FFF45};
    vecs[3]  = '{3'd1, 4'h2, 4'h3, 4'h0, 4'h4, 4'h5, 32'h0000_8000, 1'b0, 1'b1, 32'h0};
    vecs[4]  = '{3'd2, 4'h3, 4'h0, 4'h1, 4'h2, 4'h3, 32'hFFFF_8000, 1'b0, 1'b0, 32'h38000123};
    vecs[5]  = '{3'd2, 4'h3, 4'h0, 4'h1, 4'h2, 4'h3, 32'hFFFF_7FFF, 1'b0, 1'b1, 32'h0};
    vecs[6]  = '{3'd3, 4'h4, 4'h0, 4'hA, 4'hB, 4'hC, 32'h0000_FFFF, 1'b0, 1'b0, 32'h4FFFFABC};
    vecs[7]  = '{3'd3, 4'h4, 4'h0, 4'hA, 4'hB, 4'hC, 32'h0001_0000, 1'b0, 1'b1, 32'h0};
    vecs[8]  = '{3'd3, 4'h4, 4'h0, 4'hA, 4'hB, 4'hC, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0};
    vecs[9]  = '{3'd4, 4'h9, 4'h0, 4'h0, 4'h0, 4'h0, 32'h07FF_FFFF, 1'b1, 1'b0, 32'h9FFFFFFF};
    vecs[10] = '{3'd4, 4'h9, 4'h0, 4'h0, 4'h0, 4'h0, 32'h0800_0000, 1'b1, 1'b1, 32'h0};
    vecs[11] = '{3'd5, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 32'h0000_0000, 1'b0, 1'b1, 32'h0};
    vecs[12] = '{3'd7, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 32'h0000_0000, 1'b0, 1'b1, 32'h0};
    vecs[13] = '{3'd4, 4'hA, 4'h0, 4'h0, 4'h0, 4'h0, 32'h0000_0001, 1'b0, 1'b0, 32'hA0000002};

    va = '{3'd0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 32'h0, 1'b0, 1'b0, 32'h12000345};
    vb = '{3'd0, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 32'h0, 1'b0, 1'b0, 32'h6700089A};
    vc = '{3'd0, 4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 32'h0, 1'b0, 1'b0, 32'hFE000DCB};

    // Reset
    nreset = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(va);
    tick(); tick();
    check("rst in_ready",  {31'h0, in_ready},  32'h1);
    check("rst out_valid", {31'h0, out_valid}, 32'h0);
    check("rst err",       {31'h0, err},       32'h0);
    check("rst out_instr", out_instr,          32'h0);
    check_counts("rst");
    @(negedge clk); nreset = 1'b1;

    // Out-of-range C16U: err for exactly one cycle, nothing pushed
    @(negedge clk);
    drive(vecs[7]); in_valid = 1'b1;
    tick();
    exp_ec++;
    check("c16u_oor err",       {31'h0, err},       32'h1);
    check("c16u_oor out_valid", {31'h0, out_valid}, 32'h0);
    check_counts("c16u_oor");
    @(negedge clk); in_valid = 1'b0;
    tick();
    check("c16u_oor err width", {31'h0, err}, 32'h0);

    // Table: one set per cycle with out_ready high; a valid word shows up
    // one cycle after its accept and the previous word is popped meanwhile.
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(vecs[i]); in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      if (vecs[i].bad) exp_ec++;
      else             exp_wc++;
      check($sformatf("vec%0d err", i),       {31'h0, err},       {31'h0, vecs[i].bad});
      check($sformatf("vec%0d out_valid", i), {31'h0, out_valid}, {31'h0, !vecs[i].bad});
      if (!vecs[i].bad)
        check($sformatf("vec%0d out_instr", i), out_instr, vecs[i].exp);
      check_counts($sformatf("vec%0d", i));
    end
    @(negedge clk);
    tick();
    check("drain out_valid", {31'h0, out_valid}, 32'h0);
    check("drain err",       {31'h0, err},       32'h0);

    // Backpressure: third set stalls until the consumer pops
    @(negedge clk); out_ready = 1'b0; drive(va); in_valid = 1'b1;
    tick();
    check("bp1 in_ready",  {31'h0, in_ready}, 32'h1);
    check("bp1 out_instr", out_instr, va.exp);
    @(negedge clk); drive(vb);
    tick();
    exp_wc += 16'd2;
    check("bp2 in_ready",  {31'h0, in_ready}, 32'h0);
    check("bp2 out_instr", out_instr, va.exp);
    check_counts("bp2");
    @(negedge clk); drive(vc);
    tick();
    check("bp3 stalled in_ready", {31'h0, in_ready}, 32'h0);
    check("bp3 head held",        out_instr, va.exp);
    check_counts("bp3");
    @(negedge clk); out_ready = 1'b1;
    tick();
    check("bp4 out_instr", out_instr, vb.exp);
    check("bp4 in_ready",  {31'h0, in_ready}, 32'h1);
    check_counts("bp4");
    @(negedge clk);
    tick();
    exp_wc++;
    check("bp5 out_instr", out_instr, vc.exp);
    check("bp5 out_valid", {31'h0, out_valid}, 32'h1);
    check_counts("bp5");
    @(negedge clk); in_valid = 1'b0;
    tick();
    check("bp6 out_valid", {31'h0, out_valid}, 32'h0);

    // Flush a full FIFO, then flush while pushing into an empty one
    @(negedge clk); out_ready = 1'b0; drive(va); in_valid = 1'b1;
    tick();
    @(negedge clk); drive(vb);
    tick();
    exp_wc += 16'd2;
    check("fl full in_ready", {31'h0, in_ready}, 32'h0);
    @(negedge clk); in_valid = 1'b0; flush = 1'b1;
    tick();
    check("fl out_valid", {31'h0, out_valid}, 32'h0);
    check("fl in_ready",  {31'h0, in_ready},  32'h1);
    check_counts("fl");
    @(negedge clk); drive(vc); in_valid = 1'b1;
    tick();
    check("fl push out_valid", {31'h0, out_valid}, 32'h0);
    check_counts("fl push");
    @(negedge clk); flush = 1'b0; in_valid = 1'b0;
    tick();
    check("fl after out_valid", {31'h0, out_valid}, 32'h0);

    // Reset mid-stream beats flush and handshake, buffered words vanish
    @(negedge clk); drive(va); in_valid = 1'b1;
    tick();
    @(negedge clk); drive(vb);
    tick();
    @(negedge clk); nreset = 1'b0; flush = 1'b1; out_ready = 1'b1; drive(vc);
    tick();
    exp_wc = 16'h0; exp_ec = 16'h0;
    check("mrst out_valid", {31'h0, out_valid}, 32'h0);
    check("mrst in_ready",  {31'h0, in_ready},  32'h1);
    check("mrst out_instr", out_instr, 32'h0);
    check("mrst err",       {31'h0, err}, 32'h0);
    check_counts("mrst");
    @(negedge clk); nreset = 1'b1; flush = 1'b0; in_valid = 1'b0;
    tick();
    check("post_rst out_valid", {31'h0, out_valid}, 32'h0);
    check_counts("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
